multicycle_controller: RTL

- Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the register file and the immediate generator (drives its format select).
- Decodes the opcode held in the instruction register and emits per-cycle mux selects and write strobes.
- Stalls on a single memory-ready handshake.

---
 rtl/multicycle_controller_pkg.sv | 73 +++++++
 rtl/multicycle_controller_imm_src_decoder.sv | 29 ++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path:
//   - RV32I opcode constants used by the decoders
//   - branch funct3 codes that the controller resolves itself
//   - controller state enum (4-bit encoding)
//   - select encodings for result_src, alu_src_a, alu_src_b, alu_op, imm_src
// Optional build macro: ILLEGAL_TRAP_EN adds the TRAP state to the enum.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Branch conditions handled by the controller
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Controller states
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_JALR     = 4'd11,
`ifdef ILLEGAL_TRAP_EN
        ST_JALRWB   = 4'd12,
        ST_TRAP     = 4'd13
`else
        ST_JALRWB   = 4'd12
`endif
    } state_e;

    // result_src
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // alu_op
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // imm_src
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// ---------------------------------------------------------------------------
// imm_src_decoder
// Maps the opcode to the immediate generator format select. Purely
// combinational so it can be reused by single-cycle cores.
// Ports:
//   opcode  in  [OPC_W-1:0]  instr[6:0]
//   imm_src out [2:0]        000=I, 001=S, 010=B, 011=J
// ---------------------------------------------------------------------------
module imm_src_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [2:0]       imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_src = IMM_I;
            OPC_STORE:                      imm_src = IMM_S;
            OPC_BRANCH:                     imm_src = IMM_B;
            OPC_JAL:                        imm_src = IMM_J;
            default:                        imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multi-cycle RV32I core. Sequences the shared ALU,
// the unified memory port, the register file and the immediate generator.
// Optional build macro: ILLEGAL_TRAP_EN -- unknown opcodes enter a sticky
// TRAP state that raises illegal_instr; otherwise they act as a NOP.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   opcode, funct3         fields of the instruction register
//   zero                   ALU zero flag (branch resolution)
//   mem_ready              memory finished the current access this cycle
//   pc_write, ir_write,
//   mem_req, mem_write,
//   reg_write              write strobes / memory request
//   adr_src, result_src,
//   alu_src_a, alu_src_b,
//   alu_op, imm_src        datapath selects
//   illegal_instr          sticky illegal-opcode flag (0 without the macro)
// ---------------------------------------------------------------------------
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int OPC_W = 7,
    parameter int F3_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             mem_req,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [2:0]       imm_src,
    output logic             illegal_instr
);

    state_e     state_q, state_d;
    logic [2:0] imm_src_dec;

    imm_src_decoder #(.OPC_W(OPC_W)) u_imm_src_decoder (
        .opcode  (opcode),
        .imm_src (imm_src_dec)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = ST_MEMADR;
                    OPC_OP:              state_d = ST_EXEC_R;
                    OPC_OP_IMM:          state_d = ST_EXEC_I;
                    OPC_BRANCH:          state_d = ST_BRANCH;
                    OPC_JAL:             state_d = ST_JAL;
                    OPC_JALR:            state_d = ST_JALR;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_d = ST_TRAP;
`else
                    // PC was already advanced in FETCH, so this is a NOP
                    default:             state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OPC_LOAD)       state_d = ST_MEMREAD;
                else if (opcode == OPC_STORE) state_d = ST_MEMWRITE;
                else                          state_d = ST_FETCH;
            end
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:   state_d = ST_ALUWB;
            ST_EXEC_I:   state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_JALR:     state_d = ST_JALRWB;
            ST_JALRWB:   state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:     state_d = ST_TRAP;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // Output decode. Everything is forced low while rst_n is asserted so an
    // aborted instruction cannot leave a strobe active during reset.
    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        mem_req       = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        reg_write     = 1'b0;
        imm_src       = 3'b000;
        illegal_instr = 1'b0;
        if (rst_n) begin
            imm_src = imm_src_dec;
            case (state_q)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                ST_DECODE: begin
                    // oldPC + imm lands in ALUOut for branch/jal targets
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                ST_MEMWB: begin
                    result_src = RES_MEM;
                    reg_write  = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNC;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNC;
                end
                ST_ALUWB: reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    // Only beq/bne are resolved; other conditions never branch
                    pc_write  = ((funct3 == F3_BEQ) &&  zero) ||
                                ((funct3 == F3_BNE) && !zero);
                end
                ST_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                ST_JALR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALU;
                    pc_write   = 1'b1;
                end
                ST_JALRWB: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    reg_write  = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: illegal_instr = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
